// File: rtl/miter_pkg.sv
// rtl/miter_pkg.sv - shared helpers for the lockstep miter comparator
package miter_pkg;

    function automatic int chan_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int chan_lsb(input int chan, input int width);
        return chan * width;
    endfunction

    // Increment that holds at the all-ones value of a w-bit counter carried in 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int w);
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (value >= top) ? top : value + 32'd1;
    endfunction

endpackage

// File: rtl/miter_align_pipe.sv
// rtl/miter_align_pipe.sv - DEPTH-stage delay line with synchronous reset; DEPTH=0 is a wire
module miter_align_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/miter_lockstep_cmp.sv
// rtl/miter_lockstep_cmp.sv - gold-vs-gate lockstep comparator; MITER_FIRST_CAPTURE_EN builds first-mismatch capture
module miter_lockstep_cmp
    import miter_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int ALIGN_LAT = 2,
    parameter int CNT_W     = 16,
    parameter int STAMP_W   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gold_valid,
    input  logic [CHANNELS*WIDTH-1:0]          gold_data,
    input  logic [CHANNELS*WIDTH-1:0]          gold_def,
    input  logic [CHANNELS*WIDTH-1:0]          gate_data,
    input  logic [CHANNELS-1:0]                chan_en,
    input  logic                               clear,
    output logic [CHANNELS-1:0]                mismatch,
    output logic                               fail,
    output logic [CNT_W-1:0]                   mismatch_cnt,
    output logic [STAMP_W-1:0]                 cmp_count,
    output logic                               first_valid,
    output logic [chan_idx_w(CHANNELS)-1:0]    first_chan,
    output logic [STAMP_W-1:0]                 first_stamp,
    output logic [WIDTH-1:0]                   first_gold,
    output logic [WIDTH-1:0]                   first_gate
);

    localparam int BUS_W = CHANNELS * WIDTH;
    localparam int CW    = chan_idx_w(CHANNELS);

    logic               al_valid;
    logic [BUS_W-1:0]   al_data;
    logic [BUS_W-1:0]   al_def;
    logic [CHANNELS-1:0] hit;

    miter_align_pipe #(
        .DEPTH (ALIGN_LAT),
        .W     (1 + 2 * BUS_W)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  ({gold_valid, gold_def, gold_data}),
        .dout ({al_valid, al_def, al_data})
    );

    // Undefined gold bits act as don't-care and can never raise a mismatch.
    always_comb begin
        hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c] = chan_en[c] &&
                     (|((al_data[chan_lsb(c, WIDTH) +: WIDTH] ^ gate_data[chan_lsb(c, WIDTH) +: WIDTH])
                        & al_def[chan_lsb(c, WIDTH) +: WIDTH]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mismatch     <= '0;
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            cmp_count    <= '0;
        end else if (al_valid) begin
            mismatch  <= hit;
            cmp_count <= cmp_count + 1'b1;
            if (|hit) begin
                mismatch_cnt <= CNT_W'(sat_inc(32'(mismatch_cnt), CNT_W));
                fail         <= 1'b1;
            end
        end else begin
            mismatch <= '0;
        end
    end

`ifdef MITER_FIRST_CAPTURE_EN
    logic [CW-1:0]    low_chan;
    logic [WIDTH-1:0] low_gold;
    logic [WIDTH-1:0] low_gate;

    // Descending scan so the lowest mismatching channel wins.
    always_comb begin
        low_chan = '0;
        low_gold = '0;
        low_gate = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (hit[c]) begin
                low_chan = CW'(c);
                low_gold = al_data[chan_lsb(c, WIDTH) +: WIDTH];
                low_gate = gate_data[chan_lsb(c, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_stamp <= '0;
            first_gold  <= '0;
            first_gate  <= '0;
        end else if (al_valid && (|hit) && !first_valid) begin
            first_valid <= 1'b1;
            first_chan  <= low_chan;
            first_stamp <= cmp_count;
            first_gold  <= low_gold;
            first_gate  <= low_gate;
        end
    end
`else
    assign first_valid = 1'b0;
    assign first_chan  = '0;
    assign first_stamp = '0;
    assign first_gold  = '0;
    assign first_gate  = '0;
`endif

endmodule

// File: doc/miter_lockstep_cmp.md
# miter_lockstep_cmp

Runtime lockstep comparator for gold-vs-gate equivalence partitions. It generalises the single-bit, stateless output miter to CHANNELS buses of WIDTH bits. The gold stream is delayed to align with a gate stream of fixed latency, with don't-care masking per bit. It accumulates mismatch statistics and a sticky fail, and captures the first failing sample. It sits beside the design-under-check in simulation and emulation harnesses as the sequential counterpart to the formal miters.

## Interface
- CHANNELS, 4, number of compared output buses (≥1)
- WIDTH, 8, bits per channel (≥1)
- ALIGN_LAT, 2, cycles the gate stream lags the gold stream (≥0)
- CNT_W, 16, mismatch counter width
- STAMP_W, 32, compare-event counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- gold_valid  in  1  gold sample present this cycle
- gold_data  in  CHANNELS*WIDTH  gold values, channel c at [c*WIDTH +: WIDTH]
- gold_def  in  CHANNELS*WIDTH  1 = bit defined; 0 = don't care (X-equivalent)
- gate_data  in  CHANNELS*WIDTH  gate values, sampled ALIGN_LAT cycles after matching gold
- chan_en  in  CHANNELS  per-channel compare enable
- clear  in  1  synchronous clear of statistics and capture
- mismatch  out  CHANNELS  registered per-channel mismatch pulse
- fail  out  1  sticky: any mismatch since reset/clear
- mismatch_cnt  out  CNT_W  cycles with ≥1 mismatching channel, saturating
- cmp_count  out  STAMP_W  compare events since reset/clear, wrapping
- first_valid  out  1  capture registers hold a sample
- first_chan  out  max(1,$clog2(CHANNELS))  channel of first mismatch
- first_stamp  out  STAMP_W  cmp_count value at first mismatch
- first_gold, first_gate  out  WIDTH each  values on first_chan at that event

## Operation
- Align stage: gold_valid, gold_data, and gold_def pass through an ALIGN_LAT-deep register pipeline. With ALIGN_LAT=0 the pipeline is a wire.
- Compare event: the aligned valid is high. Channel c mismatches when chan_en[c] && |((gold^gate) & def) over its WIDTH bits.
- No compare event: mismatch=0, and no counter or capture changes.
- Per event: cmp_count += 1 (wraps).
- Any channel mismatches: mismatch_cnt += 1, holding at all-ones; fail ← 1.
- Capture: on the first mismatching event with first_valid=0, record first_chan (lowest index among simultaneous mismatches), first_stamp (cmp_count before increment, 0-based), first_gold, and first_gate; set first_valid. Later mismatches never overwrite.
- clear: zeroes fail, mismatch, mismatch_cnt, cmp_count, and the capture registers. The align pipeline is untouched. clear has priority over a same-cycle compare event, which is dropped entirely.
- rst: clears everything, including the align pipeline. In-flight gold samples are discarded. Gate data arriving after reset is compared only against gold accepted after reset.

## Timing
- Gold sample at cycle t is compared with gate_data at t+ALIGN_LAT.
- mismatch, fail, counters, and capture update at edge t+ALIGN_LAT+1.
- Reset value of every output and pipeline register is 0.
- fail and first_* stay stable until rst/clear. first_* is 0 while first_valid=0.
- Back-to-back gold_valid every cycle is supported at full throughput.

## Configuration
- MITER_FIRST_CAPTURE_EN defined: capture registers are implemented as described.
- Not defined: no capture registers are built. first_valid, first_chan, first_stamp, first_gold, and first_gate are tied to 0. Ports remain present.
- Everything else is identical in both builds.

## Structure
- Package miter_pkg holds:
  - the saturating-increment function
  - the channel-slice index helper
  - the channel-index width constant function
- Sub-module miter_align_pipe: a parametrised DEPTH×(1+2*CHANNELS*WIDTH) delay line with synchronous reset. With DEPTH=0 it is a passthrough.
- The top-level module holds compare, counters, and capture.

## Test plan
- ALIGN_LAT=2, 10 gold samples, identical gate stream → mismatch=0, fail=0, cmp_count=10, mismatch_cnt=0.
- Gold ch2=0xA5, gate ch2=0xA4 at compare index 3 → mismatch=4'b0100 for one cycle; fail=1; first_chan=2, first_stamp=3, first_gold=0xA5, first_gate=0xA4.
- Same gate error but gold_def ch2 bit0=0, or chan_en[2]=0 → no mismatch, fail=0.
- Channels 1 and 3 mismatch in the same event, channel 0 mismatches later → first_chan=1, and capture is unchanged afterward.
- CNT_W=4, 20 consecutive mismatching events → mismatch_cnt=15 (saturated); cmp_count=20.
- clear coincident with a mismatching event, and separately rst with 2 samples in flight → counters 0, fail=0, first_valid=0; no stale compare after rst.
